// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//  Bundles the signals between the uart receiver, the byte FIFO and the
//  consumer that drains it.
//  master modport (uart model / consumer side):
//    drives  rdy, rx_byte, rd_en, ovr_clr
//    samples rdy_clr, rd_data, empty, full, count, overrun
//  slave modport (uart_rx_fifo side): the same signals with directions swapped.
//  ADDR_W sets the pointer width; count is ADDR_W+1 bits wide.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              rdy;
  logic [7:0]        rx_byte;
  logic              rdy_clr;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              ovr_clr;

  modport master (
    output rdy, rx_byte, rd_en, ovr_clr,
    input  rdy_clr, rd_data, empty, full, count, overrun
  );

  modport slave (
    input  rdy, rx_byte, rd_en, ovr_clr,
    output rdy_clr, rd_data, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//  Receive-side byte buffer placed directly after the uart. A small capture
//  FSM watches the uart rdy level, writes each byte into a DEPTH-entry FIFO
//  and answers with a single-cycle rdy_clr pulse. The consumer drains the
//  FIFO through a show-ahead read port. A byte arriving while the FIFO is
//  full and not being popped is dropped and flagged by the sticky overrun bit.
// Ports
//  clk_50m  system clock, rising edge
//  rst_n    asynchronous active-low reset
//  bus      uart_rx_fifo_if.slave:
//             rdy/rx_byte in, rdy_clr out   (uart handshake)
//             rd_en in, rd_data/empty/full/count out (consumer read port)
//             overrun out, ovr_clr in       (sticky drop flag)
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk_50m,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } state_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                rdy_clr_q, rdy_clr_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          mem_q [DEPTH];

  logic                capture;
  logic                pop;
  logic                push;
  logic                drop;

  // Capture FSM. A byte is sampled only on the IDLE edge; afterwards we wait
  // for the uart to lower rdy so a held rdy is never captured twice.
  always_comb begin
    state_d   = state_q;
    rdy_clr_d = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rdy) begin
          capture   = 1'b1;
          rdy_clr_d = 1'b1;
          state_d   = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping. A pop on the same edge frees a slot, so a full FIFO
  // still accepts the byte when the consumer reads at that moment.
  always_comb begin
    pop       = bus.rd_en && (count_q != '0);
    push      = capture && ((count_q != FULL_CNT) || pop);
    drop      = capture && !push;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Setting wins over clearing so a drop is never lost.
    if (drop)             overrun_d = 1'b1;
    else if (bus.ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdy_clr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdy_clr_q <= rdy_clr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_50m) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_byte;
  end

  assign bus.rdy_clr = rdy_clr_q;
  assign bus.rd_data = mem_q[rd_ptr_q];
  assign bus.count   = count_q;
  assign bus.empty   = (count_q == '0);
  assign bus.full    = (count_q == FULL_CNT);
  assign bus.overrun = overrun_q;

endmodule
